// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - four-digit multiplexed seven-segment driver for packed BCD
module bcd_seg_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] bcd_in,
    input  logic        load,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_start,
    output logic        pending
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    // Segment codes, active-low, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [15:0]   active;

    logic          cnt_wrap;
    logic          frame_end;
    logic [3:0]    nibble;
    logic          upper_zero;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;
    logic          start_next;

    assign cnt_wrap  = (cnt == CNT_LAST);
    assign frame_end = cnt_wrap && (idx == 2'd3);

    // The decimal point is not used by this display.
    assign dp_n = 1'b1;

    // Per-digit dwell counter and digit index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt_wrap) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow capture and frame-aligned promotion; the promotion always uses
    // the pre-load shadow so a load on the boundary waits one more frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= 16'h0000;
            active  <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (load) begin
                shadow  <= bcd_in;
                pending <= 1'b1;
            end
        end
    end

    // Digit select, leading-zero detection and glyph decode.
    always_comb begin
        nibble     = active[idx*4 +: 4];
        upper_zero = 1'b0;
        case (idx)
            2'd1:    upper_zero = (active[15:4]  == 12'h000);
            2'd2:    upper_zero = (active[15:8]  == 8'h00);
            2'd3:    upper_zero = (active[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase

        seg_next = SEG_DASH;
        if ((BLANK_LZ != 0) && upper_zero) begin
            seg_next = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    seg_next = 7'h40;
                4'd1:    seg_next = 7'h79;
                4'd2:    seg_next = 7'h24;
                4'd3:    seg_next = 7'h30;
                4'd4:    seg_next = 7'h19;
                4'd5:    seg_next = 7'h12;
                4'd6:    seg_next = 7'h02;
                4'd7:    seg_next = 7'h78;
                4'd8:    seg_next = 7'h00;
                4'd9:    seg_next = 7'h10;
                default: seg_next = SEG_DASH;
            endcase
        end

        an_next    = ~(4'b0001 << idx);
        start_next = (idx == 2'd0) && (cnt == '0);
    end

    // Registered display outputs, one cycle behind idx/active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_n        <= 4'b1111;
            seg_n       <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            an_n        <= an_next;
            seg_n       <= seg_next;
            frame_start <= start_next;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb/tb_bcd_seg_scan.sv - randomized and directed bench for bcd_seg_scan against a frame-level model
module tb_bcd_seg_scan;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic        load = 1'b0;

    logic [3:0]  an1, an0;
    logic [6:0]  seg1, seg0;
    logic        dp1, dp0, fs1, fs0, pend1, pend0;

    int errors = 0;
    int checks = 0;

    // Model: edges since reset release, plus the captured and displayed words.
    int          k = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_active = 16'h0000;
    logic        m_pending = 1'b0;

    bcd_seg_scan #(.SCAN_DIV(SD), .BLANK_LZ(1)) dut_blank (
        .clk(clk), .reset_n(reset_n), .bcd_in(bcd_in), .load(load),
        .an_n(an1), .seg_n(seg1), .dp_n(dp1), .frame_start(fs1), .pending(pend1)
    );

    bcd_seg_scan #(.SCAN_DIV(SD), .BLANK_LZ(0)) dut_full (
        .clk(clk), .reset_n(reset_n), .bcd_in(bcd_in), .load(load),
        .an_n(an0), .seg_n(seg0), .dp_n(dp0), .frame_start(fs0), .pending(pend0)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Digit d shows blank when the number formed by digits d..3 is zero.
    function automatic logic [6:0] exp_seg(input logic [15:0] word, input int d, input int blz);
        int upper;
        upper = int'(word) >> (4 * d);
        if (blz != 0 && d > 0 && upper == 0) return 7'h7F;
        return glyph(upper % 16);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_an",  16'(an1),  16'hF);
        chk("rst_seg", 16'(seg1), 16'h7F);
        chk("rst_fs",  16'(fs1),  16'h0);
        chk("rst_pend",16'(pend1),16'h0);
        chk("rst_dp",  16'(dp1),  16'h1);
        chk("rst_an_full",  16'(an0),  16'hF);
        chk("rst_seg_full", 16'(seg0), 16'h7F);
    endtask

    task automatic model_reset();
        k = 0;
        m_shadow = 16'h0000;
        m_active = 16'h0000;
        m_pending = 1'b0;
    endtask

    // One clock: drive at the falling edge, predict, check 1 ns after the rising edge.
    task automatic tick(input logic ld, input logic [15:0] v);
        int d;
        logic [3:0] e_an;
        logic [6:0] e_seg1, e_seg0;
        logic e_fs;
        load   = ld;
        bcd_in = v;
        d      = (k / SD) % 4;
        e_an   = ~(4'b0001 << d);
        e_seg1 = exp_seg(m_active, d, 1);
        e_seg0 = exp_seg(m_active, d, 0);
        e_fs   = ((k % FRAME) == 0);
        if ((k % FRAME) == FRAME - 1 && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (ld) begin
            m_shadow  = v;
            m_pending = 1'b1;
        end
        k++;
        @(posedge clk);
        #1;
        chk("an_n",        16'(an1),   16'(e_an));
        chk("seg_n",       16'(seg1),  16'(e_seg1));
        chk("frame_start", 16'(fs1),   16'(e_fs));
        chk("pending",     16'(pend1), 16'(m_pending));
        chk("dp_n",        16'(dp1),   16'h1);
        chk("an_n_full",   16'(an0),   16'(e_an));
        chk("seg_n_full",  16'(seg0),  16'(e_seg0));
        chk("fs_full",     16'(fs0),   16'(e_fs));
        chk("pend_full",   16'(pend0), 16'(m_pending));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0000);
    endtask

    // Advance until the next drive lands on frame position p (FRAME-1 is the boundary).
    task automatic align(input int p);
        for (int i = 0; i < FRAME && (k % FRAME) != p; i++) tick(1'b0, 16'h0000);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1 chk_reset_values();
        @(posedge clk); #1 chk_reset_values();
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        idle(2 * FRAME);

        align(5);
        tick(1'b1, 16'h0042);
        idle(2 * FRAME + 4);

        tick(1'b1, 16'h4095);
        idle(2 * FRAME + 2);
        tick(1'b1, 16'h0000);
        idle(2 * FRAME + 2);
        tick(1'b1, 16'h00A0);
        idle(2 * FRAME + 2);

        align(2);
        tick(1'b1, 16'h1111);
        idle(3);
        tick(1'b1, 16'h2222);
        idle(2 * FRAME + 4);

        tick(1'b1, 16'h5678);
        align(FRAME - 1);
        tick(1'b1, 16'h3333);
        idle(3 * FRAME);

        tick(1'b1, 16'h9876);
        idle(3);
        #2 reset_n = 1'b0;
        #1 chk_reset_values();
        @(posedge clk); #1 chk_reset_values();
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        idle(FRAME + 4);

        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 9) == 0, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Time-multiplexed four-digit seven-segment driver that consumes the 16-bit packed BCD word produced by the binary-to-BCD converter and scans it onto a common-anode display. A load strobe captures the BCD word into a shadow register. The shadow register is promoted to the displayed value only at a frame boundary, so a display never shows a mix of old and new digits. Leading-zero blanking and an error glyph for non-decimal nibbles are included.

## Interface
- SCAN_DIV, 50000, clock cycles each digit stays enabled; legal range ≥ 2 (1 kHz digit rate at 50 MHz).
- BLANK_LZ, 1, 1 enables leading-zero blanking on digits 3..1; 0 shows all four digits.
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- bcd_in  input  16  packed BCD; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- load  input  1  single-cycle capture strobe; bcd_in is sampled when load=1.
- an_n  output  4  active-low digit enables; bit k drives digit k (0 = units).
- seg_n  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp_n  output  1  decimal point; held at 1 (off).
- frame_start  output  1  one-cycle pulse coincident with digit 0 becoming enabled.
- pending  output  1  1 while the shadow register holds a value not yet displayed.

## Operation
- State: scan counter `cnt` (0..SCAN_DIV-1), digit index `idx` (0..3), `shadow[15:0]`, `active[15:0]`, `pending`.
- `cnt` increments every cycle. At `cnt`=SCAN_DIV-1, `cnt`→0 and `idx` advances 0→1→2→3→0.
- Frame boundary: the terminal count with `idx`=3. At that edge, if `pending`=1, then `active`←`shadow` and `pending`←0.
- `load`=1: `shadow`←`bcd_in`, `pending`←1.
- `load` at a frame boundary: the transfer uses the pre-load `shadow`. The new value is written to `shadow`, and `pending` ends at 1.
- Multiple loads within one frame: last write wins. Earlier values are never displayed.
- Decode of the selected nibble `active[4*idx+3:4*idx]`:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex, seg_n).
  - A-F show the dash glyph 3F (only g lit).
- Leading-zero blanking (BLANK_LZ=1): digit k∈{3,2,1} shows blank 7F when every nibble k..3 of `active` is 0.
  - Digit 0 is never blanked.
  - A non-decimal nibble counts as nonzero.
- A blanked digit keeps its an_n bit asserted; only seg_n is blanked.
- an_n is one-hot-low: exactly one bit is 0 outside reset.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - Outputs: an_n=1111, seg_n=7F, dp_n=1, frame_start=0, pending=0.
  - Internal state: cnt=0, idx=0, shadow=0000, active=0000.
- Outputs are registered and reflect `idx`/`active` with one cycle of latency.
  - First rising edge after reset release: an_n=1110, seg_n=40 (units "0"), frame_start=1.
  - Digits 3..1 are blank, because active=0000.
- Each digit is enabled for exactly SCAN_DIV cycles. Frame length is 4·SCAN_DIV cycles.
- frame_start pulses for one cycle every frame, on the cycle an_n becomes 1110.
- `pending` rises on the cycle after `load` and falls on the cycle after the frame boundary that consumes it.
- Load-to-display latency: a new value first appears on the frame_start cycle of the next frame; worst case 4·SCAN_DIV+1 cycles.
- Reset asserted mid-frame immediately forces the reset values. Any pending value is discarded.

## Test plan
- SCAN_DIV=4, BLANK_LZ=1:
  - Reset, then release → an_n=1111/seg_n=7F during reset.
  - Then an_n cycles 1110,1101,1011,0111, each for 4 cycles.
  - seg_n: 40 on digit 0, 7F elsewhere; frame_start every 16 cycles.
- Load 0042 mid-frame → pending=1 until the next frame_start, then:
  - digit 0 = 24, digit 1 = 19, digits 2 and 3 = 7F.
  - The old value is shown until the boundary.
- Load 4095 → digits 3..0 = 19, 40, 10, 12. Load 0000 → only digit 0 shows 40.
- Load 00A0 → digit 1 = 3F, digit 0 = 40, digits 2 and 3 = 7F.
  - With BLANK_LZ=0, the same input gives digits 3 and 2 = 40.
- Two loads (1111 then 2222) in one frame → only 2222 is ever displayed.
- Load 3333 on the frame-boundary cycle → the old shadow is promoted. 3333 appears one frame later, with pending=1 in between.
- Reset pulse mid-frame with pending=1 → outputs return to reset values immediately. Afterwards active=0000 and pending=0.
